// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_pkg
//  Purpose  : Shared types and constants for the PS/2 character source.
//             Receiver state encoding, scan-code prefix values, the bit
//             positions of the ext/brk flags inside the 16-bit character,
//             and a helper that assembles a character word.
//  Macros   : none (see ps2_frame_rx for PS2_PARITY_CHECK_EN)
//  Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  localparam int EXT_BIT = 9;
  localparam int BRK_BIT = 8;

  // {6'b0, ext, brk, code}
  function automatic logic [15:0] make_char(input logic ext,
                                            input logic brk,
                                            input logic [7:0] code);
    logic [15:0] c;
    c          = 16'h0000;
    c[EXT_BIT] = ext;
    c[BRK_BIT] = brk;
    c[7:0]     = code;
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_frame_rx
//  Purpose  : PS/2 device-to-host frame receiver. Synchronises the raw PS/2
//             clock and data pins, detects falling edges of the PS/2 clock,
//             and walks start / 8 data (LSB first) / parity / stop bits.
//             Aborts an open frame after TIMEOUT_CYCLES edgeless cycles.
//  Macros   : PS2_PARITY_CHECK_EN - when defined, frames failing odd parity
//             are rejected with frame_err; otherwise parity is ignored.
//  Ports    : clk        in   system clock
//             rst        in   asynchronous active-low reset
//             ps2_clk    in   raw PS/2 clock pin
//             ps2_data   in   raw PS/2 data pin
//             rx_byte    out  last received byte (valid with byte_valid)
//             byte_valid out  one-cycle pulse, rx_byte holds a good byte
//             frame_err  out  one-cycle pulse on stop/parity/timeout error
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_frame_rx #(
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  import ps2_pkg::*;

  localparam int             TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          fall;
  logic          data_bit;

  rx_state_t     state;
  rx_state_t     state_next;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;
  logic [TW-1:0] timer;
  logic          timeout;
  logic          parity_ok;
  logic          valid_next;
  logic          err_next;

  assign fall     = clk_prev & ~clk_sync[1];
  assign data_bit = data_sync[1];

`ifdef PS2_PARITY_CHECK_EN
  logic parity_bit;
  // Odd parity: data plus parity bit must carry an odd number of ones.
  assign parity_ok = ^{shift, parity_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Timer counts edgeless cycles; this is the last one allowed.
  assign timeout = (state != IDLE) && !fall && (timer == TIMER_LAST);

  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    err_next   = 1'b0;
    if (timeout) begin
      state_next = IDLE;
      err_next   = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:    if (!data_bit) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (data_bit && parity_ok) valid_next = 1'b1;
          else                       err_next   = 1'b1;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // Idle line is high; starting sync flops at 1 avoids a false edge.
      clk_sync   <= 2'b11;
      data_sync  <= 2'b11;
      clk_prev   <= 1'b1;
      state      <= IDLE;
      shift      <= 8'h00;
      bit_cnt    <= 3'd0;
      timer      <= '0;
      rx_byte    <= 8'h00;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      data_sync  <= {data_sync[0], ps2_data};
      clk_prev   <= clk_sync[1];
      state      <= state_next;
      byte_valid <= valid_next;
      frame_err  <= err_next;
      if (valid_next) rx_byte <= shift;

      if (state_next == IDLE || fall) timer <= '0;
      else                            timer <= timer + TW'(1);

      if (fall) begin
        if (state == IDLE) bit_cnt <= 3'd0;
        if (state == DATA) begin
          shift   <= {data_bit, shift[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
`ifdef PS2_PARITY_CHECK_EN
        if (state == PARITY) parity_bit <= data_bit;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_char_source.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_char_source
//  Purpose  : Turns PS/2 keyboard frames into paced 16-bit characters.
//             E0/F0 prefixes are folded into ext/brk flags, completed
//             characters are queued in a FIFO, and each is presented with a
//             one-cycle newchar strobe at least GAP_CYCLES apart.
//  Macros   : PS2_PARITY_CHECK_EN (passed through to ps2_frame_rx)
//  Ports    : clk       in   system clock
//             rst       in   asynchronous active-low reset
//             ps2_clk   in   raw PS/2 clock pin
//             ps2_data  in   raw PS/2 data pin
//             newchar   out  one-cycle strobe, char updated this cycle
//             char      out  {6'b0, ext, brk, scancode}, held between strobes
//             frame_err out  one-cycle pulse on a receive error
//             overflow  out  sticky, a character was dropped (FIFO full)
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_char_source #(
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        newchar,
  output logic [15:0] char,
  output logic        frame_err,
  output logic        overflow
);
  import ps2_pkg::*;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          rx_err;

  logic          ext;
  logic          brk;
  logic          is_ext;
  logic          is_brk;
  logic          push;
  logic [15:0]   push_data;
  logic          pop;
  logic          full;
  logic          accept;

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [GW-1:0] gap;

  ps2_frame_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (rx_err)
  );

  assign frame_err = rx_err;

  assign is_ext    = (rx_byte == PS2_PREFIX_EXT);
  assign is_brk    = (rx_byte == PS2_PREFIX_BRK);
  assign push      = byte_valid && !is_ext && !is_brk;
  assign push_data = make_char(ext, brk, rx_byte);

  assign pop    = (count != '0) && (gap == '0);
  assign full   = (count == CW'(FIFO_DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (rx_err) begin
      ext <= 1'b0;
      brk <= 1'b0;
    end else if (byte_valid) begin
      if (is_ext)      ext <= 1'b1;
      else if (is_brk) brk <= 1'b1;
      else begin
        ext <= 1'b0;
        brk <= 1'b0;
      end
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      gap      <= '0;
      newchar  <= 1'b0;
      char     <= 16'h0000;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(accept) - CW'(pop);
      if (push && !accept) overflow <= 1'b1;

      newchar <= pop;
      if (pop) begin
        char <= mem[rd_ptr];
        gap  <= GW'(GAP_CYCLES);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ps2_char_source.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ps2_char_source
//  Purpose  : Directed self-checking bench for ps2_char_source. Drives PS/2
//             frames with a 20-clk bit period into two instances: the default
//             configuration and a 4-deep, slow-paced one for overflow.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_char_source;

  localparam int TIMEOUT = 5000;
  localparam int B_GAP   = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n    = 1'b0;
  logic ps2_clk  = 1'b1;
  logic ps2_data = 1'b1;

  logic        a_newchar, a_frame_err, a_overflow;
  logic [15:0] a_char;
  logic        b_newchar, b_frame_err, b_overflow;
  logic [15:0] b_char;

  ps2_char_source #(
    .FIFO_DEPTH     (8),
    .GAP_CYCLES     (8),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) u_dut (
    .clk       (clk),
    .rst       (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .newchar   (a_newchar),
    .char      (a_char),
    .frame_err (a_frame_err),
    .overflow  (a_overflow)
  );

  ps2_char_source #(
    .FIFO_DEPTH     (4),
    .GAP_CYCLES     (B_GAP),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) u_dut_small (
    .clk       (clk),
    .rst       (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .newchar   (b_newchar),
    .char      (b_char),
    .frame_err (b_frame_err),
    .overflow  (b_overflow)
  );

  int checks = 0;
  int errors = 0;

  int          cyc   = 0;
  int          a_nc  = 0;
  int          a_err = 0;
  logic [15:0] a_last = 16'h0000;
  logic [15:0] b_chars [$];
  int          b_times [$];

  always @(negedge clk) begin
    cyc++;
    if (a_newchar) begin
      a_nc++;
      a_last = a_char;
    end
    if (a_frame_err) a_err++;
    if (b_newchar) begin
      b_chars.push_back(b_char);
      b_times.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ps2_bit(input logic v);
    ps2_data = v;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(1'b1);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i]);
    ps2_data = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle(3);
    checks++;
    if (a_char !== 16'h0000) begin
      errors++; $display("FAIL reset_char: got %h expected 0000", a_char);
    end
    checks++;
    if (a_newchar !== 1'b0) begin
      errors++; $display("FAIL reset_newchar: got %b expected 0", a_newchar);
    end
    checks++;
    if (a_frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_frame_err: got %b expected 0", a_frame_err);
    end
    checks++;
    if (a_overflow !== 1'b0 || b_overflow !== 1'b0) begin
      errors++; $display("FAIL reset_overflow: got %b/%b expected 0/0", a_overflow, b_overflow);
    end
    rst_n = 1'b1;
    idle(5);
  endtask

  task automatic test_basic;
    int n0, e0;
    n0 = a_nc; e0 = a_err;
    send_frame(8'h1C, 1'b0);
    idle(60);
    checks++;
    if (a_nc - n0 !== 1) begin
      errors++; $display("FAIL basic_count: got %0d expected 1", a_nc - n0);
    end
    checks++;
    if (a_last !== 16'h001C) begin
      errors++; $display("FAIL basic_char: got %h expected 001c", a_last);
    end
    checks++;
    if (a_err - e0 !== 0) begin
      errors++; $display("FAIL basic_frame_err: got %0d expected 0", a_err - e0);
    end
  endtask

  task automatic test_prefix;
    int n0, e0;
    n0 = a_nc; e0 = a_err;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    idle(60);
    checks++;
    if (a_nc - n0 !== 1) begin
      errors++; $display("FAIL prefix_count: got %0d expected 1", a_nc - n0);
    end
    checks++;
    if (a_last !== 16'h0375) begin
      errors++; $display("FAIL prefix_char: got %h expected 0375", a_last);
    end
    send_frame(8'h1C, 1'b0);
    idle(60);
    checks++;
    if (a_nc - n0 !== 2) begin
      errors++; $display("FAIL prefix_clear_count: got %0d expected 2", a_nc - n0);
    end
    checks++;
    if (a_last !== 16'h001C || a_err !== e0) begin
      errors++; $display("FAIL prefix_clear_char: got %h errs %0d expected 001c errs 0", a_last, a_err - e0);
    end
  endtask

  task automatic test_parity;
    int n0, e0;
    n0 = a_nc; e0 = a_err;
    send_frame(8'h1C, 1'b1);
    idle(60);
`ifdef PS2_PARITY_CHECK_EN
    checks++;
    if (a_err - e0 !== 1) begin
      errors++; $display("FAIL parity_err: got %0d expected 1", a_err - e0);
    end
    checks++;
    if (a_nc - n0 !== 0) begin
      errors++; $display("FAIL parity_count: got %0d expected 0", a_nc - n0);
    end
`else
    checks++;
    if (a_nc - n0 !== 1) begin
      errors++; $display("FAIL parity_count: got %0d expected 1", a_nc - n0);
    end
    checks++;
    if (a_last !== 16'h001C) begin
      errors++; $display("FAIL parity_char: got %h expected 001c", a_last);
    end
    checks++;
    if (a_err - e0 !== 0) begin
      errors++; $display("FAIL parity_err: got %0d expected 0", a_err - e0);
    end
`endif
  endtask

  task automatic test_timeout;
    int n0, e0;
    n0 = a_nc; e0 = a_err;
    send_partial(8'h1C, 4);
    repeat (TIMEOUT + 10) @(posedge clk);
    checks++;
    if (a_err - e0 !== 1) begin
      errors++; $display("FAIL timeout_err: got %0d expected 1", a_err - e0);
    end
    checks++;
    if (a_nc - n0 !== 0) begin
      errors++; $display("FAIL timeout_count: got %0d expected 0", a_nc - n0);
    end
    send_frame(8'h1C, 1'b0);
    idle(60);
    checks++;
    if (a_nc - n0 !== 1) begin
      errors++; $display("FAIL timeout_recover_count: got %0d expected 1", a_nc - n0);
    end
    checks++;
    if (a_last !== 16'h001C) begin
      errors++; $display("FAIL timeout_recover_char: got %h expected 001c", a_last);
    end
    checks++;
    if (a_err - e0 !== 1) begin
      errors++; $display("FAIL timeout_recover_err: got %0d expected 1", a_err - e0);
    end
  endtask

  task automatic test_back_to_back;
    int base;
    logic [15:0] exp;
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(5);
    base = b_chars.size();
    for (int v = 1; v <= 6; v++) send_frame(8'(v), 1'b0);
    idle(20);
    checks++;
    if (b_overflow !== 1'b1) begin
      errors++; $display("FAIL b2b_overflow: got %b expected 1", b_overflow);
    end
    checks++;
    if (a_overflow !== 1'b0) begin
      errors++; $display("FAIL b2b_deep_overflow: got %b expected 0", a_overflow);
    end
    for (int k = 0; k < 12000 && b_chars.size() < base + 5; k++) @(negedge clk);
    checks++;
    if (b_chars.size() - base !== 5) begin
      errors++; $display("FAIL b2b_strobes: got %0d expected 5 within budget", b_chars.size() - base);
    end
    for (int i = 0; i < 5; i++) begin
      exp = 16'(i + 1);
      checks++;
      if (base + i >= b_chars.size()) begin
        errors++; $display("FAIL b2b_char%0d: got none expected %h", i, exp);
      end else if (b_chars[base + i] !== exp) begin
        errors++; $display("FAIL b2b_char%0d: got %h expected %h", i, b_chars[base + i], exp);
      end
    end
    for (int i = 1; i < 5; i++) begin
      if (base + i < b_chars.size()) begin
        checks++;
        if (b_times[base + i] - b_times[base + i - 1] < B_GAP) begin
          errors++; $display("FAIL b2b_gap%0d: got %0d cycles expected >= %0d", i,
                             b_times[base + i] - b_times[base + i - 1], B_GAP);
        end
      end
    end
    idle(3000);
    checks++;
    if (b_chars.size() - base !== 5) begin
      errors++; $display("FAIL b2b_dropped: got %0d strobes expected 5", b_chars.size() - base);
    end
    checks++;
    if (b_overflow !== 1'b1) begin
      errors++; $display("FAIL b2b_overflow_sticky: got %b expected 1", b_overflow);
    end
  endtask

  task automatic test_async_reset;
    int n0;
    send_frame(8'h1C, 1'b0);
    idle(60);
    checks++;
    if (a_char !== 16'h001C) begin
      errors++; $display("FAIL areset_pre_char: got %h expected 001c", a_char);
    end
    send_partial(8'h29, 3);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_char !== 16'h0000) begin
      errors++; $display("FAIL areset_char: got %h expected 0000", a_char);
    end
    checks++;
    if (a_newchar !== 1'b0) begin
      errors++; $display("FAIL areset_newchar: got %b expected 0", a_newchar);
    end
    checks++;
    if (a_overflow !== 1'b0 || b_overflow !== 1'b0) begin
      errors++; $display("FAIL areset_overflow: got %b/%b expected 0/0", a_overflow, b_overflow);
    end
    @(negedge clk);
    rst_n    = 1'b1;
    ps2_data = 1'b1;
    ps2_clk  = 1'b1;
    idle(5);
    n0 = a_nc;
    send_frame(8'h29, 1'b0);
    idle(60);
    checks++;
    if (a_nc - n0 !== 1) begin
      errors++; $display("FAIL areset_recover_count: got %0d expected 1", a_nc - n0);
    end
    checks++;
    if (a_last !== 16'h0029) begin
      errors++; $display("FAIL areset_recover_char: got %h expected 0029", a_last);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_timeout();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
